// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the RV32 pipeline hazard sequencer.
// Holds register-number width, sequencer states, forwarding selects and the hazard match helper.
package pipeline_hazard_ctrl_pkg;

    localparam int unsigned REG_NUM_SIZE = 5;

    typedef logic [REG_NUM_SIZE-1:0] reg_num_t;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'b00,
        HZ_MEM_WAIT = 2'b01,
        HZ_DRAIN    = 2'b10,
        HZ_HALT     = 2'b11
    } hz_state_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    // x0 is hardwired zero, so it never creates a dependency.
    function automatic logic reg_match(input reg_num_t rd, input reg_num_t rs);
        return (rd != '0) && (rd == rs);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_forward_sel.sv
// EX operand bypass select for one source operand.
// MEM result takes priority over WB result; otherwise the register file value is used.
module forward_sel
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [REG_NUM_SIZE-1:0] rs_e,
    input  logic [REG_NUM_SIZE-1:0] rd_m,
    input  logic                    we_m,
    input  logic [REG_NUM_SIZE-1:0] rd_w,
    input  logic                    we_w,
    output logic [1:0]              fwd_e
);

    always_comb begin
        fwd_e = FWD_RF;
        if (we_m && reg_match(rd_m, rs_e)) begin
            fwd_e = FWD_MEM;
        end else if (we_w && reg_match(rd_w, rs_e)) begin
            fwd_e = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard sequencer for the 5-stage RV32 pipeline: stalls, flushes, forwarding,
// data-memory wait states, EBREAK halt/drain/resume and saturating performance counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic [4:0]       rs1_e,
    input  logic [4:0]       rs2_e,
    input  logic [4:0]       rd_e,
    input  logic             load_e,
    input  logic [4:0]       rd_m,
    input  logic             we_m,
    input  logic [4:0]       rd_w,
    input  logic             we_w,
    input  logic             brn_taken_e,
    input  logic             dmem_req_m,
    input  logic             dmem_ready_m,
    input  logic             halt_d,
    input  logic             resume,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             flush_d,
    output logic             flush_e,
    output logic [1:0]       fwd1_e,
    output logic [1:0]       fwd2_e,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

    hz_state_t          state;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [1:0]         fwd1_raw;
    logic [1:0]         fwd2_raw;
    logic               mem_wait;
    logic               load_use;

    assign mem_wait = dmem_req_m && !dmem_ready_m;
    assign load_use = load_e && (reg_match(rd_e, rs1_d) || reg_match(rd_e, rs2_d));

    forward_sel u_fwd1 (
        .rs_e  (rs1_e),
        .rd_m  (rd_m),
        .we_m  (we_m),
        .rd_w  (rd_w),
        .we_w  (we_w),
        .fwd_e (fwd1_raw)
    );

    forward_sel u_fwd2 (
        .rs_e  (rs2_e),
        .rd_m  (rd_m),
        .we_m  (we_m),
        .rd_w  (rd_w),
        .we_w  (we_w),
        .fwd_e (fwd2_raw)
    );

    assign fwd1_e = rst ? fwd1_raw : FWD_RF;
    assign fwd2_e = rst ? fwd2_raw : FWD_RF;
    assign halted = rst && (state == HZ_HALT);

    // Stall/flush controls are combinational and forced quiet while reset is held.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        if (rst) begin
            case (state)
                HZ_RUN: begin
                    if (mem_wait) begin
                        {stall_f, stall_d, stall_e, stall_m} = '1;
                    end else if (brn_taken_e) begin
                        flush_d = 1'b1;
                        flush_e = 1'b1;
                    end else if (load_use || halt_d) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        flush_e = 1'b1;
                    end
                end
                HZ_MEM_WAIT: begin
                    if (!dmem_ready_m) begin
                        {stall_f, stall_d, stall_e, stall_m} = '1;
                    end
                end
                HZ_DRAIN: begin
                    if (mem_wait) begin
                        {stall_f, stall_d, stall_e, stall_m} = '1;
                    end else begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        flush_e = 1'b1;
                    end
                end
                HZ_HALT: begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                    flush_d = resume;
                end
                default: ;
            endcase
        end
    end

    // A memory wait during DRAIN stays in DRAIN with the counter frozen, so no return state is needed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= HZ_RUN;
            drain_cnt <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            case (state)
                HZ_RUN: begin
                    if (mem_wait) begin
                        state <= HZ_MEM_WAIT;
                    end else if (!brn_taken_e && !load_use && halt_d) begin
                        state     <= HZ_DRAIN;
                        drain_cnt <= DRAIN_LOAD;
                    end
                end
                HZ_MEM_WAIT: begin
                    if (dmem_ready_m) begin
                        state <= HZ_RUN;
                    end
                end
                HZ_DRAIN: begin
                    if (!mem_wait) begin
                        if (drain_cnt == '0) begin
                            state <= HZ_HALT;
                        end else begin
                            drain_cnt <= drain_cnt - 1'b1;
                        end
                    end
                end
                HZ_HALT: begin
                    if (resume) begin
                        state <= HZ_RUN;
                    end
                end
                default: state <= HZ_RUN;
            endcase

            if (stall_f && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if ((flush_d || flush_e) && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl with hand-computed expectations.
// A second instance with 2-bit counters exercises counter saturation.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       load_e, we_m, we_w, brn_taken_e, dmem_req_m, dmem_ready_m, halt_d, resume;

    logic        stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, halted;
    logic [1:0]  fwd1_e, fwd2_e;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_stall_f, s_stall_d, s_stall_e, s_stall_m, s_flush_d, s_flush_e, s_halted;
    logic [1:0]  s_fwd1_e, s_fwd2_e;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.CNT_W(16), .DRAIN_CYCLES(3)) dut (
        .clk(clk), .rst(rst),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
        .load_e(load_e), .rd_m(rd_m), .we_m(we_m), .rd_w(rd_w), .we_w(we_w),
        .brn_taken_e(brn_taken_e), .dmem_req_m(dmem_req_m), .dmem_ready_m(dmem_ready_m),
        .halt_d(halt_d), .resume(resume),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
        .flush_d(flush_d), .flush_e(flush_e), .fwd1_e(fwd1_e), .fwd2_e(fwd2_e),
        .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_hazard_ctrl #(.CNT_W(2), .DRAIN_CYCLES(3)) dut_sat (
        .clk(clk), .rst(rst),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
        .load_e(load_e), .rd_m(rd_m), .we_m(we_m), .rd_w(rd_w), .we_w(we_w),
        .brn_taken_e(brn_taken_e), .dmem_req_m(dmem_req_m), .dmem_ready_m(dmem_ready_m),
        .halt_d(halt_d), .resume(resume),
        .stall_f(s_stall_f), .stall_d(s_stall_d), .stall_e(s_stall_e), .stall_m(s_stall_m),
        .flush_d(s_flush_d), .flush_e(s_flush_e), .fwd1_e(s_fwd1_e), .fwd2_e(s_fwd2_e),
        .halted(s_halted), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e}
    function automatic logic [5:0] ctl();
        return {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e};
    endfunction

    task automatic idle();
        rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0; rd_e = '0; rd_m = '0; rd_w = '0;
        load_e = 1'b0; we_m = 1'b0; we_w = 1'b0; brn_taken_e = 1'b0;
        dmem_req_m = 1'b0; dmem_ready_m = 1'b0; halt_d = 1'b0; resume = 1'b0;
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        idle();

        // Reset with random inputs: everything quiet.
        for (int i = 0; i < 3; i++) begin
            tick();
            {rs1_d, rs2_d, rs1_e, rs2_e, rd_e} = 25'($urandom);
            {rd_m, rd_w} = 10'($urandom);
            {load_e, we_m, we_w, brn_taken_e, dmem_req_m, dmem_ready_m, halt_d, resume} = 8'($urandom);
            #1;
            check_eq("rst ctl", {26'd0, ctl()}, 32'h0);
            check_eq("rst fwd", {28'd0, fwd1_e, fwd2_e}, 32'h0);
            check_eq("rst halted", {31'd0, halted}, 32'h0);
            check_eq("rst cnt", {stall_cnt, flush_cnt}, 32'h0);
        end
        tick();
        idle();
        rst = 1'b1;
        #1;
        check_eq("post rst ctl", {26'd0, ctl()}, 32'h0);

        // Load-use on rs2.
        tick();
        load_e = 1'b1; rd_e = 5'd5; rs2_d = 5'd5;
        #1;
        check_eq("load-use ctl", {26'd0, ctl()}, 32'b110001);
        tick();
        idle();
        load_e = 1'b1; rd_e = 5'd0; rs2_d = 5'd0;
        #1;
        check_eq("load-use x0 ctl", {26'd0, ctl()}, 32'h0);
        check_eq("load-use stall_cnt", {16'd0, stall_cnt}, 32'd1);
        check_eq("load-use flush_cnt", {16'd0, flush_cnt}, 32'd1);
        check_eq("sat stall_cnt 1", {30'd0, s_stall_cnt}, 32'd1);

        // Forwarding priority and x0.
        tick();
        idle();
        rd_m = 5'd7; we_m = 1'b1; rd_w = 5'd7; we_w = 1'b1; rs1_e = 5'd7;
        #1;
        check_eq("fwd1 mem", {30'd0, fwd1_e}, 32'b10);
        check_eq("fwd2 rf", {30'd0, fwd2_e}, 32'b00);
        tick();
        we_m = 1'b0;
        #1;
        check_eq("fwd1 wb", {30'd0, fwd1_e}, 32'b01);
        tick();
        rs1_e = 5'd0; rd_m = 5'd0; we_m = 1'b1; rd_w = 5'd0;
        #1;
        check_eq("fwd1 x0", {30'd0, fwd1_e}, 32'b00);
        tick();
        rd_m = 5'd3; we_m = 1'b1; rd_w = 5'd9; we_w = 1'b1; rs1_e = 5'd9; rs2_e = 5'd3;
        #1;
        check_eq("fwd split", {28'd0, fwd1_e, fwd2_e}, 32'b0110);

        // Branch overrides load-use.
        tick();
        idle();
        brn_taken_e = 1'b1; load_e = 1'b1; rd_e = 5'd5; rs1_d = 5'd5; halt_d = 1'b1;
        #1;
        check_eq("branch ctl", {26'd0, ctl()}, 32'b000011);
        tick();
        idle();
        #1;
        check_eq("branch flush_cnt", {16'd0, flush_cnt}, 32'd2);
        check_eq("branch stall_cnt", {16'd0, stall_cnt}, 32'd1);
        check_eq("sat flush_cnt 2", {30'd0, s_flush_cnt}, 32'd2);

        // Memory wait: 4 frozen cycles, branch ignored while frozen.
        for (int i = 0; i < 4; i++) begin
            tick();
            dmem_req_m = 1'b1; dmem_ready_m = 1'b0;
            brn_taken_e = (i == 2);
            #1;
            check_eq($sformatf("memwait ctl %0d", i), {26'd0, ctl()}, 32'b111100);
        end
        tick();
        brn_taken_e = 1'b0; dmem_ready_m = 1'b1;
        #1;
        check_eq("mem ready ctl", {26'd0, ctl()}, 32'h0);
        tick();
        idle();
        #1;
        check_eq("memwait stall_cnt", {16'd0, stall_cnt}, 32'd5);
        check_eq("memwait flush_cnt", {16'd0, flush_cnt}, 32'd2);
        check_eq("sat stall_cnt hold", {30'd0, s_stall_cnt}, 32'd3);

        // EBREAK: halt_d cycle, 3 drain cycles, then HALT.
        for (int i = 0; i < 4; i++) begin
            tick();
            halt_d = 1'b1;
            #1;
            check_eq($sformatf("drain ctl %0d", i), {26'd0, ctl()}, 32'b110001);
            check_eq($sformatf("drain halted %0d", i), {31'd0, halted}, 32'h0);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            #1;
            check_eq($sformatf("halt ctl %0d", i), {26'd0, ctl()}, 32'b110001);
            check_eq($sformatf("halt halted %0d", i), {31'd0, halted}, 32'h1);
        end
        check_eq("sat halt view", {24'd0, s_stall_f, s_stall_d, s_stall_e, s_stall_m,
                                   s_flush_d, s_flush_e, s_halted, 1'b0},
                 32'b11000110);
        check_eq("sat fwd", {28'd0, s_fwd1_e, s_fwd2_e}, 32'h0);
        tick();
        resume = 1'b1;
        #1;
        check_eq("resume ctl", {26'd0, ctl()}, 32'b110011);
        tick();
        idle();
        #1;
        check_eq("resumed halted", {31'd0, halted}, 32'h0);
        check_eq("resumed ctl", {26'd0, ctl()}, 32'h0);
        check_eq("halt stall_cnt", {16'd0, stall_cnt}, 32'd12);
        check_eq("halt flush_cnt", {16'd0, flush_cnt}, 32'd9);
        check_eq("sat flush_cnt hold", {30'd0, s_flush_cnt}, 32'd3);

        // Memory wait inside DRAIN freezes the drain counter.
        tick();
        halt_d = 1'b1;
        tick();
        #1;
        check_eq("drain2 first", {26'd0, ctl()}, 32'b110001);
        tick();
        dmem_req_m = 1'b1;
        #1;
        check_eq("drain2 memwait ctl", {26'd0, ctl()}, 32'b111100);
        for (int i = 0; i < 2; i++) begin
            tick();
            dmem_req_m = 1'b0;
            #1;
            check_eq($sformatf("drain2 resume %0d", i), {31'd0, halted}, 32'h0);
        end
        tick();
        #1;
        check_eq("drain2 halted", {31'd0, halted}, 32'h1);
        tick();
        resume = 1'b1;
        tick();
        idle();

        // Reset asserted during DRAIN.
        tick();
        halt_d = 1'b1;
        tick();
        #1;
        check_eq("drain3 ctl", {26'd0, ctl()}, 32'b110001);
        #2;
        rst = 1'b0;
        #1;
        check_eq("rst in drain ctl", {26'd0, ctl()}, 32'h0);
        check_eq("rst in drain halted", {31'd0, halted}, 32'h0);
        check_eq("rst in drain cnt", {stall_cnt, flush_cnt}, 32'h0);
        tick();
        idle();
        rst = 1'b1;
        #1;
        check_eq("after rst ctl", {26'd0, ctl()}, 32'h0);
        tick();
        brn_taken_e = 1'b1;
        #1;
        check_eq("after rst run branch", {26'd0, ctl()}, 32'b000011);
        check_eq("after rst halted", {31'd0, halted}, 32'h0);
        tick();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
